run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle RV32I core. It owns the core's global advance enable, so a debug host or testbench can start, halt and single-step execution. It also halts on PC breakpoints, `EBREAK` or an instruction-count watchdog. It sits beside `monociclo`, observes `pc`/`inst` and drives `cpu_en`, which qualifies the PC update, `RUWr` and `DMWr` inside the core.

---
 rtl/run_ctrl_if.sv | 25 ++
 rtl/run_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_run_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Host-side command and breakpoint-programming bundle for run_ctrl.
// The host (debug probe or testbench) is the master; run_ctrl is the slave.
interface run_ctrl_if #(
   parameter int NUM_BP = 2
);
   localparam int SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             bp_we;
   logic [SEL_W-1:0] bp_sel;
   logic [31:0]      bp_addr;
   logic             bp_enable;

   modport master (
      output cmd_valid, cmd_op, bp_we, bp_sel, bp_addr, bp_enable,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, bp_we, bp_sel, bp_addr, bp_enable,
      output cmd_ready
   );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer for the single-cycle RV32I core: start/halt/step, PC breakpoints,
// EBREAK halt and an optional instruction watchdog enabled by the RUN_CTRL_WDOG_EN macro.
module run_ctrl #(
   parameter int NUM_BP     = 2,
   parameter int CNT_W      = 32,
   parameter int WDOG_LIMIT = 80,
   parameter int AUTO_RUN   = 1
) (
   input  logic             clk,
   input  logic             reset,
   run_ctrl_if.slave        host,
   input  logic [31:0]      pc,
   input  logic [31:0]      inst,
   output logic             cpu_en,
   output logic             halted,
   output logic [2:0]       halt_cause,
   output logic [CNT_W-1:0] retired
);
   localparam int SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_STEP   = 2'd2
   } state_t;

   localparam state_t     RESET_STATE  = (AUTO_RUN != 0) ? ST_RUN : ST_HALTED;
   localparam logic [2:0] CAUSE_NONE   = 3'd0;
   localparam logic [2:0] CAUSE_CMD    = 3'd1;
   localparam logic [2:0] CAUSE_BP     = 3'd2;
   localparam logic [2:0] CAUSE_EBREAK = 3'd3;
   localparam logic [2:0] CAUSE_STEP   = 3'd4;
   localparam logic [2:0] CAUSE_WDOG   = 3'd5;
   localparam logic [1:0] OP_RUN       = 2'd0;
   localparam logic [1:0] OP_HALT      = 2'd1;
   localparam logic [1:0] OP_STEP      = 2'd2;
   localparam logic [1:0] OP_CLEAR     = 2'd3;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   state_t           state_r, state_n;
   logic             skip_r, skip_n;
   logic [2:0]       cause_r, cause_n;
   logic             halted_r;
   logic [CNT_W-1:0] retired_r, retired_n;
   logic [31:2]      bp_addr_r [NUM_BP];
   logic             bp_en_r   [NUM_BP];

   logic       bp_hit_s, wdog_hit_s, cpu_en_s;
   logic [2:0] hit_cause_s;
   logic       cmd_ready_s, acc_s, clear_s, run_start_s;
   logic       bp_unused_s;

   // Breakpoints compare word addresses, so the byte-offset bits never matter.
   assign bp_unused_s = ^{host.bp_addr[1:0], pc[1:0]};

   assign cmd_ready_s = (state_r != ST_STEP);
   assign acc_s       = host.cmd_valid && cmd_ready_s;
   assign clear_s     = acc_s && (host.cmd_op == OP_CLEAR);
   assign run_start_s = acc_s && (host.cmd_op == OP_RUN) && (state_r == ST_HALTED);

`ifdef RUN_CTRL_WDOG_EN
   logic [31:0] wdog_r, wdog_n;

   // Watchdog next value: counts RUN retirements, restarted by CLEAR or a resume.
   always_comb begin
      if (clear_s || run_start_s) begin
         wdog_n = 32'd0;
      end else if (cpu_en_s && (state_r == ST_RUN) && (wdog_r != 32'hFFFF_FFFF)) begin
         wdog_n = wdog_r + 32'd1;
      end else begin
         wdog_n = wdog_r;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_r <= 32'd0;
      end else begin
         wdog_r <= wdog_n;
      end
   end

   assign wdog_hit_s = (wdog_r == 32'(WDOG_LIMIT));
`else
   assign wdog_hit_s = 1'b0;
`endif

   // Any enabled breakpoint matching the current word address.
   always_comb begin
      bp_hit_s = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         bp_hit_s = bp_hit_s | (bp_en_r[i] & (bp_addr_r[i] == pc[31:2]));
      end
   end

   // Prioritised halt hit; only live in RUN and suppressed on the first resumed instruction.
   always_comb begin
      if ((state_r != ST_RUN) || skip_r) begin
         hit_cause_s = CAUSE_NONE;
      end else if (inst == EBREAK_INST) begin
         hit_cause_s = CAUSE_EBREAK;
      end else if (bp_hit_s) begin
         hit_cause_s = CAUSE_BP;
      end else if (wdog_hit_s) begin
         hit_cause_s = CAUSE_WDOG;
      end else begin
         hit_cause_s = CAUSE_NONE;
      end
   end

   // Same-cycle advance enable; a hit blocks the offending instruction.
   always_comb begin
      cpu_en_s = 1'b0;
      if (reset) begin
         cpu_en_s = 1'b0;
      end else begin
         case (state_r)
            ST_RUN:    cpu_en_s = (hit_cause_s == CAUSE_NONE);
            ST_STEP:   cpu_en_s = 1'b1;
            ST_HALTED: cpu_en_s = 1'b0;
            default:   cpu_en_s = 1'b0;
         endcase
      end
   end

   // Next state, cause, skip flag and retired counter.
   always_comb begin
      state_n = state_r;
      cause_n = clear_s ? CAUSE_NONE : cause_r;
      skip_n  = skip_r && !cpu_en_s;
      if (clear_s) begin
         retired_n = '0;
      end else if (cpu_en_s && (retired_r != {CNT_W{1'b1}})) begin
         retired_n = retired_r + CNT_W'(1);
      end else begin
         retired_n = retired_r;
      end
      case (state_r)
         ST_RUN: begin
            if (hit_cause_s != CAUSE_NONE) begin
               state_n = ST_HALTED;
               cause_n = hit_cause_s;
            end else if (acc_s && (host.cmd_op == OP_HALT)) begin
               state_n = ST_HALTED;
               cause_n = CAUSE_CMD;
            end else begin
               state_n = ST_RUN;
            end
         end
         ST_HALTED: begin
            if (run_start_s) begin
               state_n = ST_RUN;
               cause_n = CAUSE_NONE;
               skip_n  = 1'b1;
            end else if (acc_s && (host.cmd_op == OP_STEP)) begin
               state_n = ST_STEP;
               skip_n  = 1'b1;
            end else begin
               state_n = ST_HALTED;
            end
         end
         ST_STEP: begin
            state_n = ST_HALTED;
            cause_n = CAUSE_STEP;
         end
         default: begin
            state_n = ST_HALTED;
         end
      endcase
   end

   // Controller state and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= RESET_STATE;
         skip_r    <= 1'b0;
         cause_r   <= CAUSE_NONE;
         halted_r  <= (RESET_STATE == ST_HALTED);
         retired_r <= '0;
      end else begin
         state_r   <= state_n;
         skip_r    <= skip_n;
         cause_r   <= cause_n;
         halted_r  <= (state_n == ST_HALTED);
         retired_r <= retired_n;
      end
   end

   // Breakpoint registers; out-of-range selects match no entry and are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_r[i] <= 30'd0;
            bp_en_r[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (host.bp_we && (host.bp_sel == SEL_W'(i))) begin
               bp_addr_r[i] <= host.bp_addr[31:2];
               bp_en_r[i]   <= host.bp_enable;
            end
         end
      end
   end

   assign host.cmd_ready = cmd_ready_s;
   assign cpu_en         = cpu_en_s;
   assign halted         = halted_r;
   assign halt_cause     = cause_r;
   assign retired        = retired_r;
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed test-plan sequence followed by random traffic,
// all compared against a cycle-level behavioural model of the run-control rules.
module tb_run_ctrl;
   localparam int NUM_BP     = 3;
   localparam int CNT_W      = 32;
   localparam int WDOG_LIMIT = 12;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int M_RUN = 0, M_HALTED = 1, M_STEP = 2;
`ifdef RUN_CTRL_WDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic [31:0]      pc, inst;
   logic             cpu_en, halted;
   logic [2:0]       halt_cause;
   logic [CNT_W-1:0] retired;

   run_ctrl_if #(.NUM_BP(NUM_BP)) bus ();

   run_ctrl #(.NUM_BP(NUM_BP), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT), .AUTO_RUN(1)) dut (
      .clk(clk), .reset(reset), .host(bus), .pc(pc), .inst(inst),
      .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // reference model
   int          m_mode;
   logic [2:0]  m_cause;
   logic [31:0] m_ret;
   int          m_wd;
   bit          m_skip;
   logic [31:0] m_bpa [NUM_BP];
   bit          m_bpe [NUM_BP];
   logic [31:0] pc_cur;
   logic [31:0] ebreak_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
   endtask

   task automatic model_reset();
      m_mode = M_RUN; m_cause = 3'd0; m_ret = 32'd0; m_wd = 0; m_skip = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         m_bpa[i] = 32'd0; m_bpe[i] = 1'b0;
      end
   endtask

   function automatic logic [2:0] hit_cause();
      if (m_mode != M_RUN || m_skip) return 3'd0;
      if (inst == EBREAK) return 3'd3;
      for (int i = 0; i < NUM_BP; i++)
         if (m_bpe[i] && (m_bpa[i][31:2] == pc[31:2])) return 3'd2;
      if (WD_ON && m_wd == WDOG_LIMIT) return 3'd5;
      return 3'd0;
   endfunction

   function automatic logic exp_en();
      if (reset) return 1'b0;
      if (m_mode == M_STEP) return 1'b1;
      if (m_mode == M_HALTED) return 1'b0;
      return (hit_cause() == 3'd0);
   endfunction

   task automatic model_edge(input logic en);
      logic [2:0] hc;
      bit acc;
      if (reset) begin
         model_reset();
      end else begin
         hc  = hit_cause();
         acc = bus.cmd_valid && (m_mode != M_STEP);
         if (acc && bus.cmd_op == 2'd3) begin
            m_ret = 32'd0; m_wd = 0; m_cause = 3'd0;
         end else begin
            if (en && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
            if (en && m_mode == M_RUN) m_wd = m_wd + 1;
         end
         if (en) m_skip = 1'b0;
         if (bus.bp_we && int'(bus.bp_sel) < NUM_BP) begin
            m_bpa[bus.bp_sel] = bus.bp_addr;
            m_bpe[bus.bp_sel] = bus.bp_enable;
         end
         if (m_mode == M_RUN) begin
            if (hc != 3'd0) begin
               m_mode = M_HALTED; m_cause = hc;
            end else if (acc && bus.cmd_op == 2'd1) begin
               m_mode = M_HALTED; m_cause = 3'd1;
            end
         end else if (m_mode == M_HALTED) begin
            if (acc && bus.cmd_op == 2'd0) begin
               m_mode = M_RUN; m_wd = 0; m_cause = 3'd0; m_skip = 1'b1;
            end else if (acc && bus.cmd_op == 2'd2) begin
               m_mode = M_STEP; m_skip = 1'b1;
            end
         end else begin
            m_mode = M_HALTED; m_cause = 3'd4;
         end
      end
   endtask

   task automatic drive_core();
      pc   = pc_cur;
      inst = (pc_cur == ebreak_pc) ? EBREAK : NOP;
   endtask

   task automatic cmd(input logic [1:0] op);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
   endtask

   // One clock: check combinational outputs, advance model and core, check registered outputs.
   task automatic cycle();
      logic en_e;
      #1;
      en_e = exp_en();
      chk("cpu_en", {31'd0, cpu_en}, {31'd0, en_e});
      if (!reset) chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, m_mode != M_STEP});
      @(posedge clk);
      model_edge(en_e);
      if (reset) pc_cur = 32'd0;
      else if (en_e) pc_cur = pc_cur + 32'd4;
      #1;
      chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALTED});
      chk("halt_cause", {29'd0, halt_cause}, {29'd0, m_cause});
      chk("retired", retired, m_ret);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.bp_we     = 1'b0;
      drive_core();
   endtask

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.bp_we = 1'b0;
      bus.bp_sel = 2'd0; bus.bp_addr = 32'd0; bus.bp_enable = 1'b0;
      pc_cur = 32'd0; ebreak_pc = 32'hFFFF_FFF0;
      drive_core();
      model_reset();

      // reset then free run
      repeat (2) cycle();
      reset = 1'b0;
      repeat (10) cycle();
      chk("run10_retired", retired, 32'd10);

      // halt, clear, program breakpoints (select 3 is out of range)
      cmd(2'd1); cycle();
      cmd(2'd3); cycle();
      chk("clear_retired", retired, 32'd0);
      bus.bp_we = 1'b1; bus.bp_sel = 2'd0; bus.bp_addr = 32'h0000_0010; bus.bp_enable = 1'b1;
      cycle();
      bus.bp_we = 1'b1; bus.bp_sel = 2'd3; bus.bp_addr = 32'h0000_0008; bus.bp_enable = 1'b1;
      cycle();

      // breakpoint at 0x10
      pc_cur = 32'd0; drive_core();
      cmd(2'd0); cycle();
      repeat (6) cycle();
      chk("bp_cause", {29'd0, halt_cause}, 32'd2);
      chk("bp_retired", retired, 32'd4);

      // single step over the breakpoint
      cmd(2'd2); cycle();
      cycle();
      chk("step_cause", {29'd0, halt_cause}, 32'd4);
      chk("step_retired", retired, 32'd5);

      // EBREAK at 0x20, then resume through it
      ebreak_pc = 32'h0000_0020; drive_core();
      cmd(2'd0); cycle();
      repeat (5) cycle();
      chk("ebreak_cause", {29'd0, halt_cause}, 32'd3);
      chk("ebreak_retired", retired, 32'd8);
      cmd(2'd0); cycle();
      repeat (20) cycle();
      chk("wdog_retired", retired, WD_ON ? 32'd20 : 32'd28);
      chk("wdog_halted", {31'd0, halted}, {31'd0, WD_ON});

      // HALT command at retired=3
      cmd(2'd0); cycle();
      cmd(2'd3); cycle();
      repeat (3) cycle();
      chk("pre_halt_retired", retired, 32'd3);
      cmd(2'd1); cycle();
      chk("halt_retired", retired, 32'd4);
      chk("halt_cause_cmd", {29'd0, halt_cause}, 32'd1);
      cmd(2'd3); cycle();
      chk("clear2_retired", retired, 32'd0);
      chk("clear2_halted", {31'd0, halted}, 32'd1);

      // reset in the middle of a step
      cmd(2'd2); cycle();
      reset = 1'b1; cycle();
      reset = 1'b0;
      chk("step_reset_retired", retired, 32'd0);
      chk("step_reset_halted", {31'd0, halted}, 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 5) == 0) cmd(2'($urandom_range(0, 3)));
         if ($urandom_range(0, 19) == 0) begin
            bus.bp_we     = 1'b1;
            bus.bp_sel    = 2'($urandom_range(0, 3));
            bus.bp_addr   = 32'($urandom_range(0, 63));
            bus.bp_enable = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 29) == 0) begin
            pc_cur = 32'($urandom_range(0, 15)) * 32'd4;
            drive_core();
         end
         if ($urandom_range(0, 39) == 0) inst = EBREAK;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
